// File: rtl/sync_filter_reg.sv
// sync_filter_reg: multi-channel input synchronizer with per-channel glitch filter.
//
// Each asynchronous channel goes through a SYNC_STAGES flop chain. A stability
// counter then accepts a new value only after it has held for STABLE_CYCLES
// enabled cycles.
//
// Ports:
//   fastClk   - sole clock, rising edge
//   reset     - synchronous, active-low reset
//   enable    - filter/update enable (the sync chain always runs)
//   dataIn    - asynchronous channel inputs [NUM_CH]
//   dataOut   - filtered, synchronized channel values [NUM_CH]
//   rise      - one-cycle pulse per channel on a dataOut 0->1 [NUM_CH]
//   fall      - one-cycle pulse per channel on a dataOut 1->0 [NUM_CH]
//   anyChange - one-cycle pulse, OR of all rise|fall bits
//
// Build option: define SYNC_FILTER_EDGE_EN to build the rise/fall/anyChange
// logic. Without it these outputs are tied to 0, and dataOut behaves the same.
module sync_filter_reg #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              fastClk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] dataIn,
  output logic [NUM_CH-1:0] dataOut,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic              anyChange
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] out_d;
  logic [NUM_CH-1:0] cand;

  assign cand = sync_q[SYNC_STAGES-1];

  // Any return of cand to dataOut clears the count, so only an unbroken run
  // of STABLE_CYCLES differing enabled samples reaches dataOut.
  always_comb begin
    out_d = dataOut;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (enable) begin
        if (cand[i] == dataOut[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntLast) begin
          out_d[i] = cand[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge fastClk) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      dataOut <= '0;
    end else begin
      sync_q[0] <= dataIn;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      cnt_q   <= cnt_d;
      dataOut <= out_d;
    end
  end

`ifdef SYNC_FILTER_EDGE_EN
  logic [NUM_CH-1:0] change;
  logic [NUM_CH-1:0] rise_q;
  logic [NUM_CH-1:0] fall_q;
  logic              any_q;

  assign change = out_d ^ dataOut;

  // Registered alongside dataOut so each pulse coincides with the first
  // cycle the new value is visible.
  always_ff @(posedge fastClk) begin
    if (!reset) begin
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      rise_q <= change & out_d;
      fall_q <= change & ~out_d;
      any_q  <= |change;
    end
  end

  assign rise      = rise_q;
  assign fall      = fall_q;
  assign anyChange = any_q;
`else
  assign rise      = '0;
  assign fall      = '0;
  assign anyChange = 1'b0;
`endif

endmodule
